ex_mem_skid_stage: RTL and testbench
====================================

// Module: ex_mem_skid_stage
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the ALU datapath. Registers the
//  32-bit ALU result plus flags and control, and decouples EX from MEM with a
//  valid/ready handshake backed by a 2-entry skid buffer. Exposes the head
//  entry as a forwarding source for ALU operand muxes.
// PARAMETERS
//  DATA_W  32  ALU result / store data width
//  REG_AW  5   destination register address width
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_n          in   1       asynchronous reset, active low
//  in_valid_i     in   1       EX presents a valid ALU op
//  in_ready_o     out  1       stage can accept (registered)
//  alu_result_i   in   DATA_W  ALU result word
//  alu_zero_i     in   1       result == 0
//  alu_ovf_i      in   1       signed add/sub overflow
//  ovf_trap_i     in   1       op traps on overflow (add/sub, not addu/subu)
//  rd_addr_i      in   REG_AW  destination register
//  reg_write_i    in   1       writes register file
//  mem_read_i     in   1       load
//  mem_write_i    in   1       store
//  store_data_i   in   DATA_W  rt value for stores
//  flush_i        in   1       kill all held entries (branch/exception)
//  out_valid_o    out  1       head entry valid toward MEM
//  out_ready_i    in   1       MEM accepts head
//  out_result_o   out  DATA_W  head ALU result
//  out_zero_o     out  1       head zero flag
//  out_rd_o       out  REG_AW  head destination
//  out_reg_write_o out 1       head regwrite (after trap gating)
//  out_mem_read_o out  1       head load
//  out_mem_write_o out 1       head store (after trap gating)
//  out_store_o    out  DATA_W  head store data
//  fwd_valid_o    out  1       out_valid_o & out_reg_write_o & out_rd_o!=0
//  exc_ovf_o      out  1       one-cycle overflow-trap pulse (feature only)
// BEHAVIOUR
//  Reset: all valids 0, in_ready_o=1, all data/control outputs 0, state EMPTY.
//  Accept = in_valid_i & in_ready_o; retire = out_valid_o & out_ready_i.
//  States (count of held entries): EMPTY(0), HALF(1, head only), FULL(2, head+skid).
//   EMPTY: accept->HALF (head<=input).
//   HALF: accept&!retire->FULL (skid<=input); retire&!accept->EMPTY;
//         accept&retire->HALF (head<=input); else hold.
//   FULL: in_ready_o=0; retire->HALF (head<=skid); else hold.
//  in_ready_o is a flop: 1 in EMPTY/HALF, 0 in FULL; never combinational from
//  out_ready_i. Zero-bubble throughput: 1 op/cycle when out_ready_i held high.
//  Latency: input accepted in cycle N appears on out_* in cycle N+1.
//  Head fields stable while out_valid_o & !out_ready_i.
//  flush_i: next state EMPTY, in_ready_o<=1, out_valid_o<=0; beats a
//   simultaneous accept (input dropped) and retire (retire still counts at MEM).
//  rd_addr 0 with reg_write: carried unchanged; fwd_valid_o masks it.
//  Reset asserted mid-operation: immediate clear, no entry survives.
// CONFIGURATION
//  Macro EX_MEM_OVF_TRAP_EN.
//   Defined: on accept with alu_ovf_i&ovf_trap_i, entry stored with reg_write=0,
//    mem_write=0; exc_ovf_o pulses 1 cycle in the cycle the entry becomes head.
//   Undefined: alu_ovf_i/ovf_trap_i ignored, controls pass unchanged,
//    exc_ovf_o tied 0.
// STRUCTURE
//  Package ex_mem_pkg: DATA_W/REG_AW defaults, packed struct ex_mem_entry_t
//   {result, zero, rd, reg_write, mem_read, mem_write, store}, state enum
//   {ST_EMPTY, ST_HALF, ST_FULL}.
//  Sub-module: ex_mem_entry_reg (enable-loaded ex_mem_entry_t flop with async
//   active-low clear), instantiated for head and skid.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid_o=0, in_ready_o=1, out_result_o=0.
//  2 Stream 8 ops result=1..8, out_ready_i=1 -> out 1..8 on consecutive cycles,
//    no bubbles, latency 1.
//  3 out_ready_i=0 while feeding 0xA,0xB,0xC -> A,B held, in_ready_o=0, C held
//    at EX; release -> A,B,C in order, none lost or duplicated.
//  4 FULL + flush_i=1 with in_valid_i=1 -> next cycle EMPTY, out_valid_o=0,
//    in_ready_o=1, input not captured.
//  5 reg_write=1 rd=0 result=0xFFFF_FFFF -> out_valid_o=1, fwd_valid_o=0;
//    rd=5 -> fwd_valid_o=1, out_result_o=0xFFFF_FFFF.
//  6 EX_MEM_OVF_TRAP_EN: 0x7FFF_FFFF+1 (ovf=1,trap=1,reg_write=1) ->
//    out_reg_write_o=0, exc_ovf_o=1 one cycle; without macro out_reg_write_o=1.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM skid stage: entry layout, occupancy states and
// the overflow-trap control gating helper.
package ex_mem_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic [DATA_W-1:0] store;
   } ex_mem_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // A trapping op keeps its result for the exception path but must not
   // update architectural state.
   function automatic ex_mem_entry_t trap_gate(input ex_mem_entry_t e, input logic trap);
      ex_mem_entry_t g;
      g           = e;
      g.reg_write = e.reg_write & ~trap;
      g.mem_write = e.mem_write & ~trap;
      return g;
   endfunction

endpackage

// File: rtl/ex_mem_skid_stage_entry_reg.sv
// ex_mem_entry_reg: enable-loaded entry register with asynchronous active-low
// clear, used for both the head and the skid slot.
module ex_mem_entry_reg
   import ex_mem_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          load,
   input  ex_mem_entry_t d,
   output ex_mem_entry_t q
);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with a 2-entry skid buffer and head forwarding.
// Optional overflow trapping is enabled by defining EX_MEM_OVF_TRAP_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_EMPTY | nothing held, in_ready_o=1
//  ST_HALF  | head valid, skid empty, in_ready_o=1
//  ST_FULL  | head and skid valid, in_ready_o=0
module ex_mem_skid_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = ex_mem_pkg::DATA_W,
   parameter int REG_AW = ex_mem_pkg::REG_AW
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   input  logic              alu_ovf_i,
   input  logic              ovf_trap_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic              reg_write_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_result_o,
   output logic              out_zero_o,
   output logic [REG_AW-1:0] out_rd_o,
   output logic              out_reg_write_o,
   output logic              out_mem_read_o,
   output logic              out_mem_write_o,
   output logic [DATA_W-1:0] out_store_o,
   output logic              fwd_valid_o,
   output logic              exc_ovf_o
);

   state_t        state, state_nxt;
   logic          ready_q;
   logic          accept, retire;
   logic          load_head, load_skid, head_from_skid;
   logic          in_trap;
   ex_mem_entry_t in_raw, in_entry, head_d, head_q, skid_q;

   assign accept = in_valid_i & ready_q;
   assign retire = out_valid_o & out_ready_i;

   assign in_raw = '{result:    alu_result_i,
                     zero:      alu_zero_i,
                     rd:        rd_addr_i,
                     reg_write: reg_write_i,
                     mem_read:  mem_read_i,
                     mem_write: mem_write_i,
                     store:     store_data_i};

`ifdef EX_MEM_OVF_TRAP_EN
   logic skid_trap_q, exc_q;

   assign in_trap  = alu_ovf_i & ovf_trap_i;
   assign in_entry = trap_gate(in_raw, in_trap);

   // Pulse follows the entry into the head slot, whichever path it took.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         skid_trap_q <= 1'b0;
         exc_q       <= 1'b0;
      end else begin
         if (load_skid) skid_trap_q <= in_trap;
         exc_q <= load_head & (head_from_skid ? skid_trap_q : in_trap);
      end
   end

   assign exc_ovf_o = exc_q;
`else
   logic unused_ovf;

   assign in_trap    = 1'b0;
   assign unused_ovf = alu_ovf_i ^ ovf_trap_i ^ in_trap;
   assign in_entry   = in_raw;
   assign exc_ovf_o  = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != ST_FULL);
      end
   end

   // Flush wins over any accept; a concurrent retire has already been seen by MEM.
   always_comb begin
      state_nxt      = state;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
      if (flush_i) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt = ST_HALF;
                  load_head = 1'b1;
               end
            end
            ST_HALF: begin
               case ({accept, retire})
                  2'b10: begin
                     state_nxt = ST_FULL;
                     load_skid = 1'b1;
                  end
                  2'b01: state_nxt = ST_EMPTY;
                  2'b11: load_head = 1'b1;
                  default: state_nxt = ST_HALF;
               endcase
            end
            ST_FULL: begin
               if (retire) begin
                  state_nxt      = ST_HALF;
                  load_head      = 1'b1;
                  head_from_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   assign head_d = head_from_skid ? skid_q : in_entry;

   ex_mem_entry_reg u_head (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .load  (load_head),
      .d     (head_d),
      .q     (head_q)
   );

   ex_mem_entry_reg u_skid (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .load  (load_skid),
      .d     (in_entry),
      .q     (skid_q)
   );

   assign in_ready_o      = ready_q;
   assign out_valid_o     = (state != ST_EMPTY);
   assign out_result_o    = head_q.result;
   assign out_zero_o      = head_q.zero;
   assign out_rd_o        = head_q.rd;
   assign out_reg_write_o = head_q.reg_write;
   assign out_mem_read_o  = head_q.mem_read;
   assign out_mem_write_o = head_q.mem_write;
   assign out_store_o     = head_q.store;
   assign fwd_valid_o     = out_valid_o & head_q.reg_write & (head_q.rd != '0);

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed scenarios plus random
// traffic, compared each cycle against a queue-based occupancy model.
module tb_ex_mem_skid_stage;

`ifdef EX_MEM_OVF_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] alu_result_i = '0;
   logic        alu_zero_i = 1'b0;
   logic        alu_ovf_i = 1'b0;
   logic        ovf_trap_i = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic        reg_write_i = 1'b0;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic [31:0] store_data_i = '0;
   logic        flush_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_result_o;
   logic        out_zero_o;
   logic [4:0]  out_rd_o;
   logic        out_reg_write_o;
   logic        out_mem_read_o;
   logic        out_mem_write_o;
   logic [31:0] out_store_o;
   logic        fwd_valid_o;
   logic        exc_ovf_o;

   always #5 clk_i = ~clk_i;

   ex_mem_skid_stage dut (
      .clk_i           (clk_i),
      .rst_n           (rst_n),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .alu_result_i    (alu_result_i),
      .alu_zero_i      (alu_zero_i),
      .alu_ovf_i       (alu_ovf_i),
      .ovf_trap_i      (ovf_trap_i),
      .rd_addr_i       (rd_addr_i),
      .reg_write_i     (reg_write_i),
      .mem_read_i      (mem_read_i),
      .mem_write_i     (mem_write_i),
      .store_data_i    (store_data_i),
      .flush_i         (flush_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_result_o    (out_result_o),
      .out_zero_o      (out_zero_o),
      .out_rd_o        (out_rd_o),
      .out_reg_write_o (out_reg_write_o),
      .out_mem_read_o  (out_mem_read_o),
      .out_mem_write_o (out_mem_write_o),
      .out_store_o     (out_store_o),
      .fwd_valid_o     (fwd_valid_o),
      .exc_ovf_o       (exc_ovf_o)
   );

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] store;
      logic        trap;
   } op_t;

   op_t q[$];
   bit  new_head = 1'b0;
   bit  last_accept = 1'b0;
   int  n_chk = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_all();
      chk("out_valid", out_valid_o, q.size() > 0);
      chk("in_ready", in_ready_o, q.size() < 2);
      if (q.size() > 0) begin
         chk("result", out_result_o, q[0].result);
         chk("zero", out_zero_o, q[0].zero);
         chk("rd", out_rd_o, q[0].rd);
         chk("reg_write", out_reg_write_o, q[0].rw);
         chk("mem_read", out_mem_read_o, q[0].mr);
         chk("mem_write", out_mem_write_o, q[0].mw);
         chk("store", out_store_o, q[0].store);
         chk("fwd_valid", fwd_valid_o, q[0].rw && q[0].rd != 0);
         chk("exc_ovf", exc_ovf_o, new_head && q[0].trap);
      end else begin
         chk("fwd_idle", fwd_valid_o, 1'b0);
         chk("exc_idle", exc_ovf_o, 1'b0);
      end
   endtask

   task automatic model_edge();
      int  pre;
      bit  acc, ret;
      op_t e;
      pre = q.size();
      acc = in_valid_i && pre < 2;
      ret = pre > 0 && out_ready_i;
      last_accept = acc && !flush_i;
      if (flush_i) begin
         q.delete();
         new_head = 1'b0;
      end else begin
         if (ret) void'(q.pop_front());
         if (acc) begin
            e.trap   = TRAP_EN && alu_ovf_i && ovf_trap_i;
            e.result = alu_result_i;
            e.zero   = alu_zero_i;
            e.rd     = rd_addr_i;
            e.rw     = reg_write_i && !e.trap;
            e.mr     = mem_read_i;
            e.mw     = mem_write_i && !e.trap;
            e.store  = store_data_i;
            q.push_back(e);
         end
         new_head = q.size() > 0 && (ret || pre == 0);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      check_all();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic put(input bit v, input logic [31:0] r, input logic [4:0] rd,
                      input bit rw, input bit ovf_tr);
      in_valid_i   = v;
      alu_result_i = r;
      alu_zero_i   = (r == 0);
      rd_addr_i    = rd;
      reg_write_i  = rw;
      mem_read_i   = 1'b0;
      mem_write_i  = 1'b0;
      store_data_i = ~r;
      alu_ovf_i    = ovf_tr;
      ovf_trap_i   = ovf_tr;
   endtask

   initial begin
      int budget;
      rst_n = 1'b0;
      #23;
      rst_n = 1'b1;
      @(posedge clk_i);
      #1;
      tick();

      // streaming, one op per cycle
      out_ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         put(1'b1, i, 5'(i), 1'b1, 1'b0);
         tick();
      end
      put(1'b0, '0, '0, 1'b0, 1'b0);
      tick();

      // backpressure: A, B held, C waits at EX
      out_ready_i = 1'b0;
      put(1'b1, 32'hA, 5'd1, 1'b1, 1'b0);
      tick();
      put(1'b1, 32'hB, 5'd2, 1'b1, 1'b0);
      tick();
      put(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
      tick();
      tick();
      out_ready_i = 1'b1;
      budget = 10;
      while (!last_accept && budget > 0) begin
         tick();
         budget--;
      end
      chk("c_accepted", last_accept, 1'b1);
      put(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (3) tick();

      // flush while FULL with a concurrent input
      out_ready_i = 1'b0;
      put(1'b1, 32'h11, 5'd4, 1'b1, 1'b0);
      tick();
      put(1'b1, 32'h22, 5'd4, 1'b1, 1'b0);
      tick();
      flush_i = 1'b1;
      put(1'b1, 32'h33, 5'd4, 1'b1, 1'b0);
      tick();
      flush_i = 1'b0;
      put(1'b0, '0, '0, 1'b0, 1'b0);
      tick();

      // forwarding masks r0
      out_ready_i = 1'b1;
      put(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
      tick();
      put(1'b1, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
      tick();
      put(1'b0, '0, '0, 1'b0, 1'b0);
      tick();

      // overflow trap, held at head to show a single-cycle pulse
      out_ready_i = 1'b0;
      put(1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b1);
      tick();
      put(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      tick();
      out_ready_i = 1'b1;
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         put($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 32'h0 : $urandom(),
             $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom()), 1'($urandom()),
             $urandom_range(0, 3) == 0);
         alu_ovf_i   = 1'($urandom());
         mem_read_i  = 1'($urandom());
         mem_write_i = 1'($urandom());
         out_ready_i = $urandom_range(0, 2) != 0;
         flush_i     = $urandom_range(0, 19) == 0;
         tick();
      end
      flush_i = 1'b0;

      // reset in the middle of traffic
      out_ready_i = 1'b0;
      put(1'b1, 32'h55, 5'd9, 1'b1, 1'b0);
      tick();
      put(1'b1, 32'h66, 5'd9, 1'b1, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      new_head = 1'b0;
      chk("rst_out_valid", out_valid_o, 1'b0);
      chk("rst_in_ready", in_ready_o, 1'b1);
      chk("rst_result", out_result_o, 32'h0);
      chk("rst_zero", out_zero_o, 1'b0);
      chk("rst_reg_write", out_reg_write_o, 1'b0);
      @(posedge clk_i);
      #1;
      rst_n = 1'b1;
      put(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      out_ready_i = 1'b1;
      put(1'b1, 32'h77, 5'd2, 1'b1, 1'b0);
      tick();
      put(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
